// File: rtl/ant_table_arbiter_pkg.sv
// ============================================================================
// Package     : ant_pkg
// Description : Shared sizes, one-hot output constants and the table access
//               record used by the ant routing table arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ant_pkg;

  // Port / table geometry
  localparam int N_PORTS = 5;                 // requesting input ports
  localparam int M_OUT   = 5;                 // one-hot output request width
  localparam int NODES   = 64;                // 8x8 mesh, index = y*8+x
  localparam int DEST_W  = $clog2(NODES);     // destination index width

  // One-hot output directions returned by the routing table
  localparam logic [M_OUT-1:0] OUT_LOCAL = 5'b10000;
  localparam logic [M_OUT-1:0] OUT_N     = 5'b01000;
  localparam logic [M_OUT-1:0] OUT_E     = 5'b00100;
  localparam logic [M_OUT-1:0] OUT_S     = 5'b00010;
  localparam logic [M_OUT-1:0] OUT_W     = 5'b00001;

  // One table access as it travels through the issue stage
  typedef struct packed {
    logic                update;
    logic [DEST_W-1:0]   dest;
    logic [N_PORTS-1:0]  parent;
  } tbl_access_t;

  // Updates are acknowledged without data; calculates return the table vector.
  function automatic logic [M_OUT-1:0] rsp_payload(input logic             upd,
                                                   input logic [M_OUT-1:0] vec);
    return upd ? '0 : vec;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ant_table_arbiter_if.sv
// ============================================================================
// Interface   : ant_table_arbiter_if
// Description : Per-port request/response bundle between the agent's routing
//               logic (master) and the table arbiter (slave).
//   i_req_val          per-port request valid, held until accepted
//   i_req_update       1 = pheromone update, 0 = calculate neighbour
//   i_req_dest         per-port destination index
//   o_req_rdy          one-hot grant
//   o_rsp_val          one-cycle response strobe
//   o_rsp_next_output  per-port table result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ant_table_arbiter_if;
  import ant_pkg::*;

  logic [N_PORTS-1:0]             i_req_val;
  logic [N_PORTS-1:0]             i_req_update;
  logic [N_PORTS-1:0][DEST_W-1:0] i_req_dest;
  logic [N_PORTS-1:0]             o_req_rdy;
  logic [N_PORTS-1:0]             o_rsp_val;
  logic [N_PORTS-1:0][M_OUT-1:0]  o_rsp_next_output;

  modport master (
    output i_req_val, i_req_update, i_req_dest,
    input  o_req_rdy, o_rsp_val, o_rsp_next_output
  );

  modport slave (
    input  i_req_val, i_req_update, i_req_dest,
    output o_req_rdy, o_rsp_val, o_rsp_next_output
  );

endinterface

`default_nettype wire

// File: rtl/ant_rr_arbiter.sv
// ============================================================================
// Module      : ant_rr_arbiter
// Description : Combinational N-way round-robin arbiter. Scans the masked
//               requests starting at ptr_i and wrapping N-1 -> 0; the first
//               active request wins.
//   req_i    request vector
//   mask_i   request qualifier (1 = eligible)
//   ptr_i    highest-priority index for this cycle
//   grant_o  one-hot grant (zero when nothing eligible)
//   idx_o    binary index of the winner
//   valid_o  a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ant_rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [N-1:0]  mask_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [N-1:0]  w_req;
  logic [PW-1:0] w_cand;
  logic          w_found;

  assign w_req = req_i & mask_i;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = PW'((int'(ptr_i) + k) % N);
      if (!w_found && w_req[w_cand]) begin
        grant_o[w_cand] = 1'b1;
        idx_o           = w_cand;
        w_found         = 1'b1;
      end
    end
    valid_o = w_found;
  end

endmodule

`default_nettype wire

// File: rtl/ant_table_arbiter.sv
// ============================================================================
// Module      : ant_table_arbiter
// Description : Shares the single ant routing table between N_PORTS
//               requesters. One access accepted per cycle (round-robin),
//               issued to the table the next cycle, response returned to the
//               originating port two cycles after acceptance.
//   clk / reset                clock, asynchronous active-high reset
//   req_if (slave)             per-port request/response bundle
//   o_tbl_update               table i_update
//   o_tbl_calculate_neighbor   table i_calculate_neighbor
//   o_tbl_dest                 table i_dest
//   o_tbl_parent               table i_parent (one-hot issuing port)
//   i_tbl_next_output          table o_next_output
//   o_busy                     request pending or in flight
// Build option: define UPDATE_PRIORITY_EN to arbitrate pending pheromone
//               updates ahead of calculate requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ant_table_arbiter
  import ant_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  ant_table_arbiter_if.slave    req_if,
  output logic                  o_tbl_update,
  output logic                  o_tbl_calculate_neighbor,
  output logic [DEST_W-1:0]     o_tbl_dest,
  output logic [N_PORTS-1:0]    o_tbl_parent,
  input  logic [M_OUT-1:0]      i_tbl_next_output,
  output logic                  o_busy
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               issue_val_q;
  tbl_access_t        issue_q;
  logic               rsp_val_q;
  logic [N_PORTS-1:0] rsp_port_q;
  logic [M_OUT-1:0]   rsp_data_q;

  logic [N_PORTS-1:0] w_grant;
  logic [PW-1:0]      w_idx;
  logic               w_any;
  tbl_access_t        w_issue_d;

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
`ifdef UPDATE_PRIORITY_EN
  logic [N_PORTS-1:0] w_upd_grant, w_cal_grant;
  logic [PW-1:0]      w_upd_idx, w_cal_idx;
  logic               w_upd_any, w_cal_any;

  ant_rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb_upd (
    .req_i   (req_if.i_req_val),
    .mask_i  (req_if.i_req_update),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_upd_grant),
    .idx_o   (w_upd_idx),
    .valid_o (w_upd_any)
  );

  ant_rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb_cal (
    .req_i   (req_if.i_req_val),
    .mask_i  (~req_if.i_req_update),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_cal_grant),
    .idx_o   (w_cal_idx),
    .valid_o (w_cal_any)
  );

  // Any eligible update shadows every calculate this cycle.
  assign w_grant = w_upd_any ? w_upd_grant : w_cal_grant;
  assign w_idx   = w_upd_any ? w_upd_idx   : w_cal_idx;
  assign w_any   = w_upd_any | w_cal_any;
`else
  ant_rr_arbiter #(.N(N_PORTS), .PW(PW)) u_arb (
    .req_i   (req_if.i_req_val),
    .mask_i  ({N_PORTS{1'b1}}),
    .ptr_i   (rr_ptr_q),
    .grant_o (w_grant),
    .idx_o   (w_idx),
    .valid_o (w_any)
  );
`endif

  // Pointer moves just past the winner; holds when nothing is accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_any) begin
      rr_ptr_d = (w_idx == PW'(N_PORTS - 1)) ? '0 : w_idx + PW'(1);
    end
  end

  always_comb begin
    w_issue_d = '0;
    if (w_any) begin
      w_issue_d.update = req_if.i_req_update[w_idx];
      w_issue_d.dest   = req_if.i_req_dest[w_idx];
      w_issue_d.parent = w_grant;
    end
  end

  // --------------------------------------------------------------------------
  // Issue and response pipeline
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      issue_val_q <= 1'b0;
      issue_q     <= '0;
      rsp_val_q   <= 1'b0;
      rsp_port_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      issue_val_q <= w_any;
      issue_q     <= w_issue_d;
      rsp_val_q   <= issue_val_q;
      rsp_port_q  <= issue_val_q ? issue_q.parent : '0;
      rsp_data_q  <= issue_val_q ? rsp_payload(issue_q.update, i_tbl_next_output) : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  logic [N_PORTS-1:0][M_OUT-1:0] w_rsp_next;

  always_comb begin
    w_rsp_next = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (rsp_val_q && rsp_port_q[p]) begin
        w_rsp_next[p] = rsp_data_q;
      end
    end
  end

  // Grant and busy are combinational from the request lines, so they are
  // forced low while reset is asserted to keep every output at zero.
  assign req_if.o_req_rdy         = reset ? '0 : w_grant;
  assign req_if.o_rsp_val         = rsp_val_q ? rsp_port_q : '0;
  assign req_if.o_rsp_next_output = w_rsp_next;

  assign o_tbl_update             = issue_val_q &  issue_q.update;
  assign o_tbl_calculate_neighbor = issue_val_q & ~issue_q.update;
  assign o_tbl_dest               = issue_val_q ? issue_q.dest   : '0;
  assign o_tbl_parent             = issue_val_q ? issue_q.parent : '0;

  assign o_busy = ~reset & ((|req_if.i_req_val) | issue_val_q | rsp_val_q);

endmodule

`default_nettype wire

// File: doc/ant_table_arbiter.md
Name: ant_table_arbiter

Overview:
Shares the single ant routing table between the N per-port requesters of an ant agent.
- Requests are either next-hop calculation (normal packets, forward ants) or pheromone update (backward ants).
- Serialises them round-robin: one table access per cycle.
- Returns the table's next-output vector to the originating port two cycles after acceptance.
- Sits between the agent's per-port routing logic and ant_routing_table.

Parameters:
N_PORTS, 5, number of requesting input ports (matches `N)
M_OUT, 5, width of one-hot output request vector (matches `M)
DEST_W, $clog2(`NODES), width of destination node index (y*8+x)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_req_val  in  N_PORTS  per-port request valid; held until accepted
i_req_update  in  N_PORTS  1 = pheromone update, 0 = calculate neighbour
i_req_dest  in  N_PORTS x DEST_W  per-port destination index
o_req_rdy  out  N_PORTS  one-hot grant; request accepted when val & rdy
o_rsp_val  out  N_PORTS  one-cycle response strobe to originating port
o_rsp_next_output  out  N_PORTS x M_OUT  table result for that port
o_tbl_update  out  1  to table i_update
o_tbl_calculate_neighbor  out  1  to table i_calculate_neighbor
o_tbl_dest  out  DEST_W  to table i_dest
o_tbl_parent  out  N_PORTS  to table i_parent, one-hot of issuing port
i_tbl_next_output  in  M_OUT  from table o_next_output
o_busy  out  1  any request in flight or pending

Behaviour:
- Reset (async, active-high): rr pointer = 0; issue and response registers cleared; all outputs 0.
- Reset mid-operation: in-flight requests are dropped and receive no response. Requesters re-present them.
- Arbitration (comb, cycle t): scan ports starting at rr_ptr, wrapping N_PORTS-1 -> 0. First port with i_req_val wins. o_req_rdy is one-hot or zero.
- Round-robin update: on accept, rr_ptr <= winner+1 mod N_PORTS. With no request, rr_ptr holds.
- Stage 1, edge end of t: issue reg <= {valid, port one-hot, update, dest}.
- Stage 2, cycle t+1: table outputs driven from issue reg.
  - o_tbl_update = valid & update.
  - o_tbl_calculate_neighbor = valid & ~update.
  - When not valid, dest and parent = 0.
- Edge end of t+1: response reg <= {port, i_tbl_next_output}.
- Cycle t+2: o_rsp_val[port] = 1 for exactly one cycle.
  - Calculate: o_rsp_next_output[port] = captured vector.
  - Update: o_rsp_next_output[port] = 0 (ack only).
  - Non-responding ports drive 0.
- Throughput and latency: one accept per cycle, fully pipelined, fixed latency 2 cycles accept-to-response.
- Ordering: accesses reach the table in accept order. An update accepted at t is committed by the table before a calculate accepted at t+1 reads it.
- Protocol rules:
  - A port may re-request in the cycle its response arrives, or earlier. Multiple outstanding requests per port are allowed and return in order.
  - A requester must not drop i_req_val or change its fields before rdy.
- All ports requesting continuously: each port is granted exactly once per N_PORTS cycles (no starvation).
- o_busy = |i_req_val | issue.valid | rsp.valid.

Optional Feature:
UPDATE_PRIORITY_EN
- Defined:
  - Two-level arbitration. If any valid request has i_req_update = 1, round-robin runs only among update requests; otherwise among calculate requests.
  - A single shared rr_ptr advances on every grant.
  - Calculates can starve under continuous updates; this is accepted as a tuning choice that speeds pheromone convergence.
- Undefined: plain round-robin across all requests, as described above.

Decomposition:
- Shared package (ant_pkg):
  - table access typedef struct {logic update; logic [DEST_W-1:0] dest; logic [N_PORTS-1:0] parent;}.
  - DEST_W and the one-hot output constants OUT_LOCAL=5'b10000, OUT_N=01000, OUT_E=00100, OUT_S=00010, OUT_W=00001.
- One natural sub-module, ant_rr_arbiter: parameterised N-way round-robin with a request mask input. It is reused for the masked update/calculate levels under UPDATE_PRIORITY_EN.

Test Plan:
- Single calculate: port 2 requests dest=9 at t, table returns 5'b00100 -> rdy[2] at t; tbl_calculate_neighbor=1, dest=9, parent=00100 at t+1; rsp_val[2]=1, next_output=00100 at t+2.
- All 5 ports hold val for 10 cycles from reset -> grants 0,1,2,3,4,0,1,2,3,4; each port gets exactly 2 responses.
- Update then calculate, same dest: port 4 update dest=17 at t, port 0 calculate dest=17 at t+1 -> tbl_update at t+1, tbl_calculate at t+2. rsp_val[4] at t+2 with data 0; rsp_val[0] at t+3.
- Reset pulse the cycle after accepting port 1 -> no rsp_val, rr_ptr=0, all outputs 0 asynchronously.
- Idle rr_ptr hold: grant port 3, idle 4 cycles, then ports 0 and 4 request -> port 4 granted first.
- UPDATE_PRIORITY_EN: port 0 calculate and port 3 update requested together -> port 3 granted first, port 0 next cycle. With the macro undefined -> port 0 first.
